cap_sense_scanner: RTL and testbench
====================================

# cap_sense_scanner

Scanner for the nine capacitive touch pads of the whack-a-mole board. It drives the shared charge line `capacitive_sensors_out`, times each pad's decay on `capacitive_sensors_in[8:0]`, classifies each pad as touched or not, and debounces the result. It exposes debounced `touched` levels and sticky `press_latch` bits that the processor's memory-mapped I/O reads and clears. It is the input-side counterpart of the processor's LED command path.

## Interface
Parameters:
- `CHARGE_CYCLES`, 500: number of cycles the charge line is held high per scan.
- `MAX_COUNT`, 4095: measurement timeout, in cycles; a pad count saturates here.
- `THRESHOLD`, 200: a pad is raw-touched when its count ≥ THRESHOLD.
- `DEBOUNCE`, 3: number of consecutive agreeing scans required to change `touched`.
- `CW`, 12: counter width; must satisfy MAX_COUNT < 2^CW.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: run continuous scans.
- `capacitive_sensors_in` in 9: raw pad inputs, asynchronous.
- `capacitive_sensors_out` out 1: charge drive.
- `touched` out 9: debounced touch level per pad.
- `press_latch` out 9: sticky bit, set on each rising edge of `touched[i]`.
- `press_clr` in 9: one-cycle clear strobe per pad, issued by a processor write.
- `scan_done` out 1: one-cycle pulse at the end of each scan.

## Operation
- Inputs pass through a 2-flop synchronizer before any use.
- FSM states and transitions:
  - IDLE: drive out=0. Go to CHARGE when `enable`=1.
  - CHARGE: drive out=1 for exactly CHARGE_CYCLES cycles, then go to MEASURE.
  - MEASURE: drive out=0. The counter starts at 0 on the first MEASURE cycle and increments every cycle.
    - In each cycle, every pad not yet captured whose synchronized input is 0 captures the current counter value.
    - Exit MEASURE when all 9 pads are captured, or when counter == MAX_COUNT. Pads still uncaptured at that point get count = MAX_COUNT.
  - EVAL: one cycle.
    - raw[i] = (count[i] ≥ THRESHOLD).
    - Update debounce.
    - Pulse `scan_done`.
    - Go to CHARGE if `enable`=1, else IDLE.
- Deasserting `enable` mid-scan does not abort: the current scan completes through EVAL, then the FSM goes to IDLE.
- Debounce, per pad:
  - An agree counter counts consecutive scans where raw[i] ≠ touched[i].
  - When the counter reaches DEBOUNCE, `touched[i]` flips and the counter clears.
  - Any scan with raw[i] == touched[i] clears the counter.
- Press latch:
  - `press_latch[i]` sets in the cycle `touched[i]` goes 0→1.
  - `press_clr[i]` clears it.
  - If set and clear occur in the same cycle, set wins.
  - Clearing a bit that is already clear has no effect.

## Timing
- Reset values: out=0, `touched`=0, `press_latch`=0, `scan_done`=0. FSM=IDLE, all counters 0, synchronizer flops 0.
- `reset` asserted in any state, including mid-MEASURE, forces all reset values on the next edge. A partial scan is discarded.
- Scan period = CHARGE_CYCLES + M + 1 cycles, where M is the number of MEASURE cycles (1..MAX_COUNT+1).
- Synchronizer latency: a pad that falls k cycles after out falls is captured with count = k+2, assuming a 1-cycle input path.
- `touched` and `press_latch` update in the same cycle `scan_done` is high, and are visible the cycle after.
- `press_clr` takes effect on the next edge.

## Structure
- Package `cap_sense_pkg` holds:
  - the FSM state enum (IDLE, CHARGE, MEASURE, EVAL);
  - the parameter defaults;
  - the constant NUM_PADS=9.
- Sub-module `cap_sense_channel`, instantiated 9 times, contains the per-pad logic: synchronizer, capture register with captured flag, raw compare, debounce counter, touched flop, press latch.
- The top level holds the FSM, the charge/measure counter, and the all-captured reduction.

## Test plan
All scenarios use CHARGE_CYCLES=4, MAX_COUNT=31, THRESHOLD=10, DEBOUNCE=2.
- Reset, then hold `enable`=0 for 20 cycles -> out stays 0; `touched`, `press_latch` and `scan_done` all stay 0.
- `enable`=1; all pads fall 3 cycles after out falls -> out high for exactly 4 cycles; counts = 5; `scan_done` every 4+6+1=11 cycles; `touched` stays 0.
- Pad 4 falls at 15 cycles for one scan, then at 3 cycles -> `touched[4]` stays 0. Pad 4 falls at 15 cycles for two consecutive scans -> `touched[4]`=1 and `press_latch[4]`=1 after the second `scan_done`.
- Pad 0 held high, all other pads fall early -> MEASURE lasts 32 cycles; count[0]=31; `touched[0]`=1 after 2 scans.
- `press_clr[4]` asserted in the same cycle that `press_latch[4]` sets -> `press_latch[4]`=1. A later lone `press_clr[4]` -> 0 next cycle. `touched[4]` is unaffected throughout.
- `reset` pulsed mid-MEASURE -> next cycle: out=0, FSM=IDLE, `touched`=0, `press_latch`=0; no `scan_done` pulse for the aborted scan.

Source files
------------

// File: rtl/cap_sense_pkg.sv
// Shared types and defaults for the capacitive pad scanner.
// Holds the scan FSM state encoding, parameter defaults and pad count.
package cap_sense_pkg;

    localparam int NUM_PADS          = 9;
    localparam int CHARGE_CYCLES_DEF = 500;
    localparam int MAX_COUNT_DEF     = 4095;
    localparam int THRESHOLD_DEF     = 200;
    localparam int DEBOUNCE_DEF      = 3;
    localparam int CW_DEF            = 12;

    typedef enum logic [1:0] {
        IDLE,
        CHARGE,
        MEASURE,
        EVAL
    } state_t;

endpackage

// File: rtl/cap_sense_channel.sv
// Per-pad logic: input synchronizer, decay capture, touch classification,
// debounce and sticky press latch.
// Ports: clock/reset; pad_in (async pad); charge/measure/meas_end/eval
// phase strobes and cnt from the scanner; press_clr strobe;
// done (pad captured or capturing now), touched, press_latch.
module cap_sense_channel
    import cap_sense_pkg::*;
#(
    parameter int MAX_COUNT = MAX_COUNT_DEF,
    parameter int THRESHOLD = THRESHOLD_DEF,
    parameter int DEBOUNCE  = DEBOUNCE_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pad_in,
    input  logic          charge,
    input  logic          measure,
    input  logic          meas_end,
    input  logic          eval,
    input  logic [CW-1:0] cnt,
    input  logic          press_clr,
    output logic          done,
    output logic          touched,
    output logic          press_latch
);

    localparam int DW = $clog2(DEBOUNCE + 1);

    logic [1:0]    sync;
    logic          pad;
    logic          captured;
    logic [CW-1:0] count;
    logic [DW-1:0] agree;
    logic          raw;
    logic          flip;

    assign pad  = sync[1];
    // Lets the scanner leave MEASURE on the same edge the last pad captures.
    assign done = captured | ~pad;
    assign raw  = (count >= CW'(THRESHOLD));
    assign flip = (raw != touched) && (agree == DW'(DEBOUNCE - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            sync        <= '0;
            captured    <= 1'b0;
            count       <= '0;
            agree       <= '0;
            touched     <= 1'b0;
            press_latch <= 1'b0;
        end else begin
            sync <= {sync[0], pad_in};

            if (charge) begin
                captured <= 1'b0;
            end else if (measure && !captured) begin
                if (!pad) begin
                    count    <= cnt;
                    captured <= 1'b1;
                end else if (meas_end) begin
                    count    <= CW'(MAX_COUNT);
                    captured <= 1'b1;
                end
            end

            if (eval) begin
                if (raw == touched) begin
                    agree <= '0;
                end else if (flip) begin
                    agree   <= '0;
                    touched <= ~touched;
                end else begin
                    agree <= agree + DW'(1);
                end
            end

            // A rising touch wins over a simultaneous clear.
            press_latch <= (press_latch & ~press_clr)
                         | (eval & flip & ~touched);
        end
    end

endmodule

// File: rtl/cap_sense_scanner.sv
// Nine-pad capacitive touch scanner: charges the shared line, times each
// pad's decay, and reports debounced touch levels and sticky press bits.
// Ports: clock, reset (sync, active-high), enable, capacitive_sensors_in[8:0],
// capacitive_sensors_out, touched[8:0], press_latch[8:0], press_clr[8:0],
// scan_done (one-cycle pulse during the evaluation cycle).
module cap_sense_scanner
    import cap_sense_pkg::*;
#(
    parameter int CHARGE_CYCLES = CHARGE_CYCLES_DEF,
    parameter int MAX_COUNT     = MAX_COUNT_DEF,
    parameter int THRESHOLD     = THRESHOLD_DEF,
    parameter int DEBOUNCE      = DEBOUNCE_DEF,
    parameter int CW            = CW_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_PADS-1:0] capacitive_sensors_in,
    output logic                capacitive_sensors_out,
    output logic [NUM_PADS-1:0] touched,
    output logic [NUM_PADS-1:0] press_latch,
    input  logic [NUM_PADS-1:0] press_clr,
    output logic                scan_done
);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [NUM_PADS-1:0] done;
    logic                all_done;
    logic                meas_end;
    logic                is_charge;
    logic                is_measure;
    logic                is_eval;

    assign all_done   = &done;
    assign is_charge  = (state == CHARGE);
    assign is_measure = (state == MEASURE);
    assign is_eval    = (state == EVAL);
    assign meas_end   = is_measure
                      && (all_done || cnt == CW'(MAX_COUNT));

    always_ff @(posedge clock) begin
        if (reset) begin
            state                  <= IDLE;
            cnt                    <= '0;
            capacitive_sensors_out <= 1'b0;
            scan_done              <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state                  <= CHARGE;
                        cnt                    <= '0;
                        capacitive_sensors_out <= 1'b1;
                    end
                end
                CHARGE: begin
                    if (cnt == CW'(CHARGE_CYCLES - 1)) begin
                        state                  <= MEASURE;
                        cnt                    <= '0;
                        capacitive_sensors_out <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                MEASURE: begin
                    if (meas_end) begin
                        state     <= EVAL;
                        scan_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                EVAL: begin
                    cnt <= '0;
                    if (enable) begin
                        state                  <= CHARGE;
                        capacitive_sensors_out <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_ch
        cap_sense_channel #(
            .MAX_COUNT(MAX_COUNT),
            .THRESHOLD(THRESHOLD),
            .DEBOUNCE (DEBOUNCE),
            .CW       (CW)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .pad_in     (capacitive_sensors_in[i]),
            .charge     (is_charge),
            .measure    (is_measure),
            .meas_end   (meas_end),
            .eval       (is_eval),
            .cnt        (cnt),
            .press_clr  (press_clr[i]),
            .done       (done[i]),
            .touched    (touched[i]),
            .press_latch(press_latch[i])
        );
    end

endmodule

// File: tb/tb_cap_sense_scanner.sv
// Self-checking bench for cap_sense_scanner with a pad-decay model
// and a scan-level reference model of counts, debounce and latches.
`timescale 1ns/1ps
module tb_cap_sense_scanner;
    import cap_sense_pkg::*;

    localparam int CC   = 4;
    localparam int MAXC = 31;
    localparam int TH   = 10;
    localparam int DB   = 2;
    localparam int NP   = 9;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [NP-1:0] pads = '0;
    logic [NP-1:0] press_clr = '0;
    logic          out;
    logic          scan_done;
    logic [NP-1:0] touched;
    logic [NP-1:0] press_latch;

    int n_tests = 0;
    int n_fail  = 0;

    // Cycle, after the charge line falls, at which each pad decays; -1 = never.
    int fall_k [NP];

    logic [NP-1:0] m_touched = '0;
    logic [NP-1:0] m_latch   = '0;
    int            m_streak [NP];
    int            lead_cyc = 0;
    int            lead_hi  = 0;

    cap_sense_scanner #(
        .CHARGE_CYCLES(CC),
        .MAX_COUNT    (MAXC),
        .THRESHOLD    (TH),
        .DEBOUNCE     (DB),
        .CW           (12)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .enable                (enable),
        .capacitive_sensors_in (pads),
        .capacitive_sensors_out(out),
        .touched               (touched),
        .press_latch           (press_latch),
        .press_clr             (press_clr),
        .scan_done             (scan_done)
    );

    always #5 clock = ~clock;

    // Pads charge while the line is high and each decays k cycles after it falls.
    initial begin : pad_driver
        int   since;
        logic prev;
        since = -1;
        prev  = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (out) begin
                pads  = '1;
                since = -1;
            end else begin
                if (prev) since = 0;
                else if (since >= 0 && since < 100000) since++;
                for (int i = 0; i < NP; i++)
                    if (since >= 0 && fall_k[i] >= 0 && since >= fall_k[i])
                        pads[i] = 1'b0;
            end
            prev = out;
        end
    end

    // One scan at the level of the behaviour: decay time -> count -> touch.
    // Returns expected cycles between scan_done pulses.
    function automatic int model_scan(input logic [NP-1:0] clr);
        int            c;
        int            mx;
        logic          raw;
        logic [NP-1:0] rise;
        mx   = 0;
        rise = '0;
        for (int i = 0; i < NP; i++) begin
            if (fall_k[i] < 0 || fall_k[i] + 2 > MAXC) c = MAXC;
            else c = fall_k[i] + 2;
            if (c > mx) mx = c;
            raw = (c >= TH);
            if (raw != m_touched[i]) begin
                m_streak[i]++;
                if (m_streak[i] >= DB) begin
                    m_touched[i] = raw;
                    m_streak[i]  = 0;
                    rise[i]      = raw;
                end
            end else begin
                m_streak[i] = 0;
            end
        end
        m_latch = (m_latch & ~clr) | rise;
        return CC + (mx + 1) + 1;
    endfunction

    task automatic do_scan(input string tag, input logic [NP-1:0] clr);
        int cyc;
        int hi;
        int exp_p;
        bit seen;
        exp_p = model_scan(clr);
        cyc   = lead_cyc;
        hi    = lead_hi;
        seen  = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (out) hi++;
            if (scan_done) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s timeout: no scan_done in %0d cycles", tag, cyc);
        end else begin
            n_tests++;
            if (cyc !== exp_p) begin
                n_fail++;
                $display("FAIL %s period: got %0d want %0d", tag, cyc, exp_p);
            end
            n_tests++;
            if (hi !== CC) begin
                n_fail++;
                $display("FAIL %s charge_len: got %0d want %0d", tag, hi, CC);
            end
        end
        press_clr = clr;
        @(negedge clock);
        press_clr = '0;
        lead_cyc  = 1;
        lead_hi   = out ? 1 : 0;
        n_tests++;
        if (scan_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_width: got %b want 0", tag, scan_done);
        end
        n_tests++;
        if (touched !== m_touched) begin
            n_fail++;
            $display("FAIL %s touched: got %h want %h", tag, touched, m_touched);
        end
        n_tests++;
        if (press_latch !== m_latch) begin
            n_fail++;
            $display("FAIL %s latch: got %h want %h", tag, press_latch, m_latch);
        end
    endtask

    task automatic set_all(input int k);
        for (int i = 0; i < NP; i++) fall_k[i] = k;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NP; i++) m_streak[i] = 0;
        set_all(3);
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            n_tests++;
            if ({out, scan_done, touched, press_latch} !== '0) begin
                n_fail++;
                $display("FAIL idle cyc%0d: out=%b done=%b t=%h l=%h want 0",
                         c, out, scan_done, touched, press_latch);
            end
        end
    endtask

    task automatic test_nominal();
        set_all(3);
        enable   = 1'b1;
        lead_cyc = 0;
        lead_hi  = 0;
        for (int s = 0; s < 3; s++) do_scan("nominal", '0);
    endtask

    task automatic test_debounce();
        fall_k[4] = 15;
        do_scan("db_one", '0);
        fall_k[4] = 3;
        do_scan("db_back", '0);
        fall_k[4] = 15;
        do_scan("db_two_a", '0);
        do_scan("db_two_b", '0);
        n_tests++;
        if (touched[4] !== 1'b1 || press_latch[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL db_pad4: got t=%b l=%b want 1 1",
                     touched[4], press_latch[4]);
        end
    endtask

    task automatic test_press_clr();
        press_clr = 9'h010;
        @(negedge clock);
        press_clr = '0;
        lead_cyc++;
        if (out) lead_hi++;
        m_latch[4] = 1'b0;
        n_tests++;
        if (press_latch[4] !== 1'b0 || touched[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_lone: got l=%b t=%b want 0 1",
                     press_latch[4], touched[4]);
        end
        fall_k[4] = 3;
        do_scan("clr_rel_a", '0);
        do_scan("clr_rel_b", '0);
        fall_k[4] = 15;
        do_scan("clr_press_a", '0);
        do_scan("clr_press_b", 9'h010);
        n_tests++;
        if (press_latch[4] !== 1'b1 || touched[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_setwins: got l=%b t=%b want 1 1",
                     press_latch[4], touched[4]);
        end
    endtask

    task automatic test_timeout();
        set_all(0);
        fall_k[0] = -1;
        do_scan("tmo_a", '0);
        do_scan("tmo_b", '0);
        n_tests++;
        if (touched[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_pad0: got %b want 1", touched[0]);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 30; s++) begin
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 9) < 4) begin
                    if ($urandom_range(0, 7) == 0) fall_k[i] = -1;
                    else fall_k[i] = int'($urandom_range(0, 12));
                end
            end
            do_scan("random", 9'($urandom_range(0, 511)));
        end
    endtask

    task automatic test_reset_mid();
        int n;
        set_all(12);
        for (int s = 0; s < 3; s++) do_scan("pre_rst", '0);
        set_all(-1);
        n = 0;
        while (out && n < 50) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        n_tests++;
        if (dut.state !== MEASURE || touched !== 9'h1FF) begin
            n_fail++;
            $display("FAIL rst_pre: got state=%0d t=%h want %0d 1ff",
                     dut.state, touched, MEASURE);
        end
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({out, scan_done, touched, press_latch} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: out=%b done=%b t=%h l=%h want 0",
                     out, scan_done, touched, press_latch);
        end
        n_tests++;
        if (dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL rst_state: got %0d want %0d", dut.state, IDLE);
        end
        reset = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clock);
            if (scan_done) n++;
        end
        n_tests++;
        if (n !== 0) begin
            n_fail++;
            $display("FAIL rst_nodone: got %0d pulses want 0", n);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_debounce();
        test_press_clr();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
